mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the CPU instruction bus (I) and data bus (D). Used for configurations where IwAddress/DwAddress traffic must reach one unified RAM. Each side uses a request/acknowledge handshake. The arbiter latches the winning request, issues one memory access, waits a fixed read latency, then returns an ack pulse and the read data.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// +------------------------------------------------------------------+
// | mem_port_arbiter: I/D request arbiter onto one single-port RAM    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int READ_LATENCY  = 1,
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIReq,
  input  logic        iIWrite,
  input  logic [3:0]  iIByteEnable,
  input  logic [31:0] iIAddress,
  input  logic [31:0] iIWriteData,
  output logic [31:0] oIReadData,
  output logic        oIAck,
  input  logic        iDReq,
  input  logic        iDWrite,
  input  logic [3:0]  iDByteEnable,
  input  logic [31:0] iDAddress,
  input  logic [31:0] iDWriteData,
  output logic [31:0] oDReadData,
  output logic        oDAck,
  output logic        oMReadEnable,
  output logic        oMWriteEnable,
  output logic [3:0]  oMByteEnable,
  output logic [31:0] oMAddress,
  output logic [31:0] oMWriteData,
  input  logic [31:0] iMReadData,
  output logic [1:0]  oGrant,
  output logic [2:0]  mArbState
);

  localparam logic [2:0] C_LATENCY = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        own_d_q, own_d_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_d;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    own_d_d   = own_d_q;
    wr_d      = wr_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (iIReq || iDReq) begin
          // On a tie D wins in fixed-priority mode, otherwise the side not served last
          pick_d   = iDReq && (!iIReq || PRIORITY_MODE || !last_d_q);
          own_d_d  = pick_d;
          last_d_d = pick_d;
          wr_d     = pick_d ? iDWrite      : iIWrite;
          be_d     = pick_d ? iDByteEnable : iIByteEnable;
          addr_d   = pick_d ? iDAddress    : iIAddress;
          wdata_d  = pick_d ? iDWriteData  : iIWriteData;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = C_LATENCY;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (own_d_q) d_rdata_d = iMReadData;
          else         i_rdata_d = iMReadData;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      own_d_q   <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= 3'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      own_d_q   <= own_d_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Address/data follow the latched transaction so they stay stable through WAIT
  assign oMAddress     = addr_q;
  assign oMByteEnable  = be_q;
  assign oMWriteData   = wdata_q;
  assign oMReadEnable  = (state_q == ISSUE) && !wr_q;
  assign oMWriteEnable = (state_q == ISSUE) && wr_q;
  assign oGrant        = (state_q == IDLE) ? 2'b00 : {own_d_q, !own_d_q};
  assign mArbState     = {1'b0, state_q};
  assign oIAck         = (state_q == DONE) && !own_d_q;
  assign oDAck         = (state_q == DONE) && own_d_q;
  assign oIReadData    = i_rdata_q;
  assign oDReadData    = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses defaults, instance 1 uses
// READ_LATENCY=3 with D-priority; a transaction-timeline model is checked every cycle.
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ireq[2], iwr[2], dreq[2], dwr[2];
  logic [3:0]  ibe[2], dbe[2];
  logic [31:0] iaddr[2], iwd[2], daddr[2], dwd[2];
  logic [31:0] mrd;

  logic [31:0] ird[2], drd[2], maddr[2], mwd[2];
  logic        iack[2], dack[2], ren[2], wen[2];
  logic [3:0]  mbe[2];
  logic [1:0]  gnt[2];
  logic [2:0]  st[2];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.READ_LATENCY(1), .PRIORITY_MODE(1'b0)) u_dut0 (
    .iCLK(clk), .iRST(rst_n),
    .iIReq(ireq[0]), .iIWrite(iwr[0]), .iIByteEnable(ibe[0]), .iIAddress(iaddr[0]),
    .iIWriteData(iwd[0]), .oIReadData(ird[0]), .oIAck(iack[0]),
    .iDReq(dreq[0]), .iDWrite(dwr[0]), .iDByteEnable(dbe[0]), .iDAddress(daddr[0]),
    .iDWriteData(dwd[0]), .oDReadData(drd[0]), .oDAck(dack[0]),
    .oMReadEnable(ren[0]), .oMWriteEnable(wen[0]), .oMByteEnable(mbe[0]),
    .oMAddress(maddr[0]), .oMWriteData(mwd[0]), .iMReadData(mrd),
    .oGrant(gnt[0]), .mArbState(st[0])
  );

  mem_port_arbiter #(.READ_LATENCY(3), .PRIORITY_MODE(1'b1)) u_dut1 (
    .iCLK(clk), .iRST(rst_n),
    .iIReq(ireq[1]), .iIWrite(iwr[1]), .iIByteEnable(ibe[1]), .iIAddress(iaddr[1]),
    .iIWriteData(iwd[1]), .oIReadData(ird[1]), .oIAck(iack[1]),
    .iDReq(dreq[1]), .iDWrite(dwr[1]), .iDByteEnable(dbe[1]), .iDAddress(daddr[1]),
    .iDWriteData(dwd[1]), .oDReadData(drd[1]), .oDAck(dack[1]),
    .oMReadEnable(ren[1]), .oMWriteEnable(wen[1]), .oMByteEnable(mbe[1]),
    .oMAddress(maddr[1]), .oMWriteData(mwd[1]), .iMReadData(mrd),
    .oGrant(gnt[1]), .mArbState(st[1])
  );

  task automatic cmp(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL inst%0d %s got %h expected %h at %0t", k, nm, got, exp, $time);
    end
  endtask

  // Model: a transaction occupies cycles t=1..ack_cycle after the grant cycle
  bit          m_busy[2], m_side[2], m_wr[2], m_lastd[2];
  int          m_t[2];
  logic [3:0]  m_be[2];
  logic [31:0] m_addr[2], m_wd[2], m_rdi[2], m_rdd[2];

  function automatic int rl(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int ack_cycle(input int k);
    return m_wr[k] ? 2 : 2 + rl(k);
  endfunction

  always @(posedge clk) begin
    bit pd;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_t[k] = 0; m_side[k] = 0; m_wr[k] = 0; m_lastd[k] = 1;
        m_be[k] = 0; m_addr[k] = 0; m_wd[k] = 0; m_rdi[k] = 0; m_rdd[k] = 0;
      end else if (m_busy[k]) begin
        if (!m_wr[k] && m_t[k] == 1 + rl(k)) begin
          if (m_side[k]) m_rdd[k] = mrd;
          else           m_rdi[k] = mrd;
        end
        if (m_t[k] == ack_cycle(k)) m_busy[k] = 0;
        else                        m_t[k]++;
      end else if (ireq[k] || dreq[k]) begin
        if (ireq[k] && dreq[k]) pd = (k == 1) ? 1'b1 : !m_lastd[k];
        else                    pd = dreq[k];
        m_side[k]  = pd;
        m_lastd[k] = pd;
        m_wr[k]    = pd ? dwr[k]   : iwr[k];
        m_be[k]    = pd ? dbe[k]   : ibe[k];
        m_addr[k]  = pd ? daddr[k] : iaddr[k];
        m_wd[k]    = pd ? dwd[k]   : iwd[k];
        m_busy[k]  = 1;
        m_t[k]     = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit b, issue, ackc;
    for (int k = 0; k < 2; k++) begin
      b     = rst_n && m_busy[k];
      issue = b && m_t[k] == 1;
      ackc  = b && m_t[k] == ack_cycle(k);
      cmp(k, "ren", ren[k], issue && !m_wr[k]);
      cmp(k, "wen", wen[k], issue && m_wr[k]);
      cmp(k, "grant", gnt[k], !b ? 2'b00 : (m_side[k] ? 2'b10 : 2'b01));
      cmp(k, "state", st[k], !b ? 3'd0 : issue ? 3'd1 : ackc ? 3'd3 : 3'd2);
      cmp(k, "iack", iack[k], ackc && !m_side[k]);
      cmp(k, "dack", dack[k], ackc && m_side[k]);
      cmp(k, "ird", ird[k], rst_n ? m_rdi[k] : 32'd0);
      cmp(k, "drd", drd[k], rst_n ? m_rdd[k] : 32'd0);
      if (b) begin
        cmp(k, "maddr", maddr[k], m_addr[k]);
        cmp(k, "mbe", mbe[k], {28'd0, m_be[k]});
        cmp(k, "mwd", mwd[k], m_wd[k]);
      end else if (!rst_n) begin
        cmp(k, "maddr_rst", maddr[k], 32'd0);
        cmp(k, "mwd_rst", mwd[k], 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    mrd = $urandom;
  endtask

  logic [1:0] seq[4];
  logic [1:0] exp_rr[4];
  logic [1:0] exp_pr[4];
  int n;
  int dlow;

  initial begin
    rst_n = 1'b0;
    mrd   = 32'd0;
    for (int k = 0; k < 2; k++) begin
      ireq[k] = 0; iwr[k] = 0; ibe[k] = 4'hF; iaddr[k] = 0; iwd[k] = 0;
      dreq[k] = 0; dwr[k] = 0; dbe[k] = 4'hF; daddr[k] = 0; dwd[k] = 0;
    end
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    exp_pr[0] = 2'b10; exp_pr[1] = 2'b01; exp_pr[2] = 2'b10; exp_pr[3] = 2'b01;

    cyc();
    cmp(0, "rst_state", st[0], 3'd0);
    cmp(0, "rst_grant", gnt[0], 2'b00);
    cmp(0, "rst_ren", ren[0], 1'b0);
    cmp(0, "rst_ird", ird[0], 32'd0);
    cmp(1, "rst_drd", drd[1], 32'd0);
    cyc();
    rst_n = 1'b1;

    // Round-robin contention from reset: I wins the first tie
    ireq[0] = 1; iaddr[0] = 32'h100; dreq[0] = 1; daddr[0] = 32'h200;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      cyc();
      if (st[0] == 3'd1) begin seq[n] = gnt[0]; n++; end
    end
    cmp(0, "rr_count", n, 4);
    for (int i = 0; i < 4 && i < n; i++) cmp(0, "rr_order", seq[i], exp_rr[i]);
    ireq[0] = 0; dreq[0] = 0;
    repeat (6) cyc();

    // I read of 0x00400000; memory returns 0x13 one cycle after the strobe
    iaddr[0] = 32'h0040_0000; iwr[0] = 0; ireq[0] = 1;
    cyc();
    ireq[0] = 0;
    cmp(0, "t1_ren", ren[0], 1'b1);
    cmp(0, "t1_addr", maddr[0], 32'h0040_0000);
    cyc();
    mrd = 32'h0000_0013;
    cmp(0, "t1_ren_off", ren[0], 1'b0);
    cmp(0, "t1_noack", iack[0], 1'b0);
    cyc();
    cmp(0, "t1_ack", iack[0], 1'b1);
    cmp(0, "t1_rdata", ird[0], 32'h0000_0013);
    cyc();
    cmp(0, "t1_ack_off", iack[0], 1'b0);
    repeat (2) cyc();

    // D write
    daddr[0] = 32'h1001_0004; dwd[0] = 32'hDEAD_BEEF; dbe[0] = 4'b0011; dwr[0] = 1; dreq[0] = 1;
    cyc();
    dreq[0] = 0;
    cmp(0, "t2_wen", wen[0], 1'b1);
    cmp(0, "t2_be", mbe[0], 32'h3);
    cmp(0, "t2_wdata", mwd[0], 32'hDEAD_BEEF);
    cmp(0, "t2_addr", maddr[0], 32'h1001_0004);
    cmp(0, "t2_noack", dack[0], 1'b0);
    cyc();
    cmp(0, "t2_ack", dack[0], 1'b1);
    repeat (3) cyc();

    // D-priority: D drops req after each ack so I gets the following grant
    ireq[1] = 1; iaddr[1] = 32'h300; dreq[1] = 1; daddr[1] = 32'h400;
    n = 0; dlow = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      cyc();
      if (dlow > 0) begin
        dlow--;
        if (dlow == 0) dreq[1] = 1;
      end
      if (dack[1]) begin dreq[1] = 0; dlow = 2; end
      if (st[1] == 3'd1) begin seq[n] = gnt[1]; n++; end
    end
    cmp(1, "pr_count", n, 4);
    for (int i = 0; i < 4 && i < n; i++) cmp(1, "pr_order", seq[i], exp_pr[i]);
    ireq[1] = 0; dreq[1] = 0;
    repeat (12) cyc();

    // D read with latency 3: only the value at the capture edge is taken
    daddr[1] = 32'h2000; dwr[1] = 0; dreq[1] = 1;
    cyc();
    dreq[1] = 0;
    cyc(); mrd = 32'h111;
    cyc(); mrd = 32'h222;
    cyc(); mrd = 32'h333;
    cmp(1, "t4_noack", dack[1], 1'b0);
    cyc();
    cmp(1, "t4_ack", dack[1], 1'b1);
    cmp(1, "t4_rdata", drd[1], 32'h333);
    repeat (2) cyc();

    // Address change after grant does not reach the memory port
    iaddr[1] = 32'h0000_1234; iwr[1] = 0; ireq[1] = 1;
    cyc();
    ireq[1] = 0;
    cyc();
    iaddr[1] = 32'hFFFF_FFFF;
    cyc();
    cmp(1, "t5_addr", maddr[1], 32'h0000_1234);
    repeat (2) cyc();
    cmp(1, "t5_ack", iack[1], 1'b1);
    repeat (2) cyc();

    // Asynchronous reset during WAIT aborts the transaction
    iaddr[1] = 32'h40; ireq[1] = 1;
    cyc();
    ireq[1] = 0;
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    cmp(1, "t6_state", st[1], 3'd0);
    cmp(1, "t6_grant", gnt[1], 2'b00);
    cmp(1, "t6_iack", iack[1], 1'b0);
    cmp(1, "t6_ren", ren[1], 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    daddr[1] = 32'h55; dwd[1] = 32'hCAFE_0001; dbe[1] = 4'hF; dwr[1] = 1; dreq[1] = 1;
    cyc();
    dreq[1] = 0;
    cmp(1, "t6_wen", wen[1], 1'b1);
    cyc();
    cmp(1, "t6_dack", dack[1], 1'b1);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
